// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: reset vector, fetch FSM states and
// target-formation constants.
package cpu_pkg;

    // First fetch address after reset.
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Sequential PC increment (one 32-bit instruction).
    localparam logic [31:0] PC_INC = 32'd4;

    // Number of upper PC bits a jump keeps from the PC+4 of the jump.
    localparam int unsigned JUMP_HI_BITS = 4;

    // Fetch-stage states.
    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StWait,
        StStall
    } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: forms the jump, branch and sequential targets and picks
// one with priority jump > branch > sequential. Purely combinational.
module pc_next_sel #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_base_i,
    input  logic [ADDR_W-1:0] branch_off_i,
    input  logic [25:0]       jump_index_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] seq_pc_o,
    output logic [ADDR_W-1:0] next_pc_o
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] branch_tgt;

    // Target arithmetic; all sums wrap modulo 2^ADDR_W.
    always_comb begin
        jump_tgt   = {branch_base_i[ADDR_W-1 -: JUMP_HI_BITS], jump_index_i, 2'b00};
        branch_tgt = branch_base_i + branch_off_i;
        seq_pc_o   = pc_i + PC_INC;
    end

    // Priority select: jump beats branch beats fall-through.
    always_comb begin
        redirect_o = jump_i | branch_taken_i;
        next_pc_o  = seq_pc_o;
        if (jump_i) begin
            next_pc_o = jump_tgt;
        end else if (branch_taken_i) begin
            next_pc_o = branch_tgt;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory handshake,
// holds a one-entry skid buffer for returns that land during a stall, and
// drives the IF/ID register plus the wrong-path flush.
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] branch_base_i,
    input  logic [ADDR_W-1:0] branch_off_i,
    input  logic [25:0]       jump_index_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       if_instr_o,
    output logic [ADDR_W-1:0] if_pc4_o,
    output logic              if_valid_o,
    output logic              flush_o
);
    import cpu_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic [31:0]       if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc4_q, if_pc4_d;
    logic              if_valid_q, if_valid_d;

    logic              skid_valid_q, skid_valid_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;

    // A redirect that arrived while a request was still outstanding.
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    logic              sel_redirect;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              busy;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .pc_i           (pc_q),
        .jump_i         (jump_i),
        .branch_taken_i (branch_taken_i),
        .branch_base_i  (branch_base_i),
        .branch_off_i   (branch_off_i),
        .jump_index_i   (jump_index_i),
        .redirect_o     (sel_redirect),
        .seq_pc_o       (seq_pc),
        .next_pc_o      (next_pc)
    );

    // Handshake and flush outputs; redirects are ignored during stall and boot.
    always_comb begin
        busy        = (state_q == StFetch) || (state_q == StWait);
        redirect    = sel_redirect && !stall_i && (state_q != StBoot);
        imem_req_o  = busy;
        imem_addr_o = pc_q;
        flush_o     = redirect;
        if_instr_o  = if_instr_q;
        if_pc4_o    = if_pc4_q;
        if_valid_o  = if_valid_q;
    end

    // Next-state logic for the FSM, PC, IF/ID register, skid and pending redirect.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;
        // A stall freezes IF/ID; otherwise the slot empties unless refilled below.
        if_valid_d   = stall_i ? if_valid_q : 1'b0;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;

        if (redirect) begin
            skid_valid_d = 1'b0;
        end

        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end

            StFetch, StWait: begin
                if (imem_ready_i) begin
                    if (redirect) begin
                        // Returned word is wrong-path; go straight to the target.
                        pc_d    = next_pc;
                        pend_d  = 1'b0;
                        state_d = StFetch;
                    end else if (pend_q) begin
                        // Drain of the request that was overtaken by a redirect.
                        pc_d    = pend_tgt_q;
                        pend_d  = 1'b0;
                        state_d = StFetch;
                    end else if (stall_i) begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata_i;
                        skid_pc4_d   = seq_pc;
                        pc_d         = seq_pc;
                        state_d      = StStall;
                    end else begin
                        if_instr_d = imem_rdata_i;
                        if_pc4_d   = seq_pc;
                        if_valid_d = 1'b1;
                        pc_d       = seq_pc;
                        state_d    = StFetch;
                    end
                end else begin
                    // Address must stay put while the request is outstanding.
                    state_d = StWait;
                    if (redirect) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = next_pc;
                    end
                end
            end

            StStall: begin
                if (!stall_i) begin
                    state_d      = StFetch;
                    skid_valid_d = 1'b0;
                    if (redirect) begin
                        pc_d = next_pc;
                    end else begin
                        if_instr_d = skid_instr_q;
                        if_pc4_d   = skid_pc4_q;
                        if_valid_d = skid_valid_q;
                    end
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            if_instr_q   <= '0;
            if_pc4_q     <= '0;
            if_valid_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            pend_q       <= 1'b0;
            pend_tgt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_instr_q   <= if_instr_d;
            if_pc4_q     <= if_pc4_d;
            if_valid_q   <= if_valid_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined CPU: holds the program counter, issues instruction-memory requests, and drives the IF/ID outputs.
- Consumes the shifted branch offset (sign-extended immediate already shifted left by two) and the ID-stage PC+4 to form branch and jump targets.
- Provides the flush pulse that kills the wrong-path IF/ID entry.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, address/PC width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall_i  in  1  hazard-unit stall; freezes PC and IF/ID outputs
- branch_taken_i  in  1  ID-stage branch resolved taken
- jump_i  in  1  ID-stage unconditional jump
- branch_base_i  in  32  PC+4 of the instruction in ID
- branch_off_i  in  32  sign-extended immediate, already shifted left 2
- jump_index_i  in  26  jump instruction index field
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address; stable while request is outstanding
- imem_ready_i  in  1  memory returns imem_rdata_i this cycle; completes the request
- imem_rdata_i  in  32  fetched instruction
- if_instr_o  out  32  instruction to IF/ID
- if_pc4_o  out  32  PC+4 of if_instr_o
- if_valid_o  out  1  if_instr_o is a live instruction
- flush_o  out  1  combinational kill of the current IF/ID entry

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc=RESET_PC; state=BOOT.
  - imem_req_o=0, if_instr_o=0, if_pc4_o=0, if_valid_o=0, flush_o=0.
  - Skid buffer and redirect-pending flag cleared.
  - Reset mid-request abandons the request; any later imem_ready_i is ignored until FETCH.
- FSM states BOOT, FETCH, WAIT, STALL:
  - BOOT -> FETCH after one cycle.
  - FETCH: imem_req_o=1, imem_addr_o=pc.
    - imem_ready_i=0 -> WAIT.
    - imem_ready_i=1 and stall_i=0 -> capture into the IF/ID outputs at the next edge (if_valid_o=1 unless squashed); pc <= pc+4; stay in FETCH.
    - imem_ready_i=1 and stall_i=1 -> instruction goes into the 1-entry skid buffer; -> STALL.
  - WAIT: req and addr held; on imem_ready_i, apply the same rules as FETCH.
  - STALL: imem_req_o=0; PC and IF/ID outputs frozen. When stall_i falls, the skid entry (if any) moves to the outputs, then -> FETCH.
  - stall_i=1 in FETCH with no ready: request continues; stall only takes effect at completion.
- Next PC, priority jump > branch > sequential:
  - jump target = {branch_base_i[31:28], jump_index_i, 2'b00}.
  - branch target = branch_base_i + branch_off_i, modulo 2^32; wrap permitted, no overflow flag.
  - sequential = pc+4, wraps at 32'hFFFF_FFFC -> 0.
- Redirect (jump_i|branch_taken_i while stall_i=0):
  - flush_o=1 the same cycle.
  - At the next edge: if_valid_o=0, skid cleared.
  - No request outstanding, or imem_ready_i=1 this cycle: pc <= target and the returned data is discarded; next imem_addr_o=target.
  - Request outstanding without ready: address held, target latched in redirect-pending; the eventual data is discarded, then target is fetched.
  - Redirect while stall_i=1 is ignored; flush_o=0.
  - A second redirect while one is pending overwrites the target.
- Latency: redirect at cycle N -> imem_addr_o=target at N+1; with ready at N+1, if_valid_o=1 with target instruction at N+2.
- Sequential throughput is one instruction per cycle when imem_ready_i is held high.

Decomposition:
- Shared package cpu_pkg holds: RESET_PC, the fetch-state enum, the 32'd4 increment constant, and JUMP_HI_BITS=4.
- One sub-module: pc_next_sel. Purely combinational; computes jump, branch and sequential targets with priority, so it can be tested in isolation.

Test Plan:
- Reset then imem_ready_i=1 held -> imem_addr_o sequence 0,4,8,C; if_instr_o follows one cycle later; if_pc4_o=4,8,C.
- At pc=0x10, branch_taken_i with branch_base_i=0x0C, branch_off_i=0xFFFF_FFF8 -> flush_o=1 that cycle; next imem_addr_o=0x04; squashed instruction has if_valid_o=0.
- jump_i and branch_taken_i together, branch_base_i=0x4000_0010, jump_index_i=26'h000_0040 -> next address 0x4000_0100 (jump wins).
- imem_ready_i low 3 cycles at addr 0x20, branch redirect during the wait -> addr held at 0x20; returned data discarded; following fetch 0x100 (branch_base_i=0x1C, off=0xE4).
- Return at addr 0x30 coincides with stall_i=1 for 2 cycles -> outputs frozen, imem_req_o=0; on release if_instr_o=data from 0x30, then fetch 0x34.
- rst_n=0 during WAIT at 0x50 -> next cycle all outputs zero; first request after BOOT is RESET_PC; a late imem_ready_i is ignored.
